// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM bank and future motion blocks.
package servo_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    JOG  = 2'd1,
    RAMP = 2'd2
  } chan_state_t;

  function automatic logic [31:0] clamp_u32(input logic [31:0] value,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/servo_chan.sv
// One servo channel: HOLD/JOG/RAMP state machine, saturating position stepping,
// period-aligned shadow duty and the registered PWM output.
module servo_chan
  import servo_pkg::*;
#(
  parameter int W        = 17,
  parameter int PW       = 20,
  parameter int MIN_CYC  = 25_000,
  parameter int MAX_CYC  = 125_000,
  parameter int HOME_CYC = 75_000,
  parameter int STEP_CYC = 1_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          en,
  input  logic          tick,
  input  logic          period_last,
  input  logic [PW-1:0] period_cnt,
  input  logic          inc,
  input  logic          dec,
  input  logic          cmd_load,
  input  logic [W-1:0]  cmd_pos,
  output logic          pwm,
  output logic [W-1:0]  pos,
  output logic          busy
);

  localparam logic [W-1:0] MIN_W  = MIN_CYC[W-1:0];
  localparam logic [W-1:0] MAX_W  = MAX_CYC[W-1:0];
  localparam logic [W-1:0] HOME_W = HOME_CYC[W-1:0];
  localparam logic [W-1:0] STEP_W = STEP_CYC[W-1:0];
  localparam logic [W:0]   STEP_X = STEP_CYC[W:0];

  chan_state_t  state, state_nxt;
  logic [W-1:0] target, target_nxt, pos_nxt, shadow;
  logic         jog;
  logic [W:0]   up_sum, down_floor, gap;

  // Sums carry one extra bit so saturation never wraps.
  always_comb begin
    jog        = inc ^ dec;
    up_sum     = {1'b0, pos} + STEP_X;
    down_floor = {1'b0, MIN_W} + STEP_X;
    gap        = (target > pos) ? ({1'b0, target} - {1'b0, pos})
                                : ({1'b0, pos} - {1'b0, target});
    state_nxt  = state;
    pos_nxt    = pos;
    target_nxt = target;

    if (en) begin
      if (tick) begin
        case (state)
          JOG: begin
            if (inc && !dec)
              pos_nxt = (up_sum > {1'b0, MAX_W}) ? MAX_W : up_sum[W-1:0];
            else if (dec && !inc)
              pos_nxt = ({1'b0, pos} < down_floor) ? MIN_W : (pos - STEP_W);
          end
          RAMP: begin
            if (!jog) begin
              if (gap > STEP_X)
                pos_nxt = (target > pos) ? (pos + STEP_W) : (pos - STEP_W);
              else
                pos_nxt = target;
            end
          end
          default: ;
        endcase
      end

      // A jog always beats a same-cycle command to this channel.
      if (jog) begin
        state_nxt = JOG;
        if (state == RAMP) target_nxt = pos;
      end else if (cmd_load) begin
        state_nxt  = RAMP;
        target_nxt = W'(clamp_u32(32'(cmd_pos), MIN_CYC, MAX_CYC));
      end else begin
        case (state)
          JOG:     state_nxt = HOLD;
          RAMP:    if (pos == target) state_nxt = HOLD;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= HOLD;
      pos    <= HOME_W;
      target <= HOME_W;
      shadow <= HOME_W;
      pwm    <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      target <= target_nxt;
      if (period_last) shadow <= pos;
      pwm    <= en && (32'(period_cnt) < 32'(shadow));
    end
  end

  assign busy = (state == RAMP);

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of hobby-servo PWM channels sharing period/step timebases and a
// valid/ready absolute-target command port.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int N_CH       = 3,
  parameter int PERIOD_CYC = 1_000_000,
  parameter int TICK_CYC   = 3_000_000,
  parameter int MIN_CYC    = 25_000,
  parameter int MAX_CYC    = 125_000,
  parameter int HOME_CYC   = 75_000,
  parameter int STEP_CYC   = 1_000,
  localparam int W         = $clog2(MAX_CYC + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [N_CH-1:0]   inc,
  input  logic [N_CH-1:0]   dec,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [W-1:0]      cmd_pos,
  output logic              cmd_err,
  output logic [N_CH-1:0]   pwm,
  output logic [N_CH*W-1:0] pos,
  output logic              busy
);

  localparam int PW     = $clog2(PERIOD_CYC);
  localparam int TW     = $clog2(TICK_CYC);
  localparam int P_LAST = PERIOD_CYC - 1;
  localparam int T_LAST = TICK_CYC - 1;
  localparam logic [PW-1:0] PERIOD_LAST = P_LAST[PW-1:0];
  localparam logic [TW-1:0] TICK_LAST   = T_LAST[TW-1:0];

  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   tick_cnt;
  logic            period_last, tick, cmd_accept;
  logic [N_CH-1:0] busy_vec;

  assign period_last = (period_cnt == PERIOD_LAST);
  assign tick        = (tick_cnt == TICK_LAST);
  assign cmd_ready   = en;
  assign cmd_accept  = cmd_valid && cmd_ready;

  // Timebases free-run regardless of en so the PWM phase never drifts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_cnt <= '0;
      tick_cnt   <= '0;
      cmd_err    <= 1'b0;
    end else begin
      period_cnt <= period_last ? '0 : (period_cnt + PW'(1));
      tick_cnt   <= tick ? '0 : (tick_cnt + TW'(1));
      cmd_err    <= cmd_accept && (int'(cmd_ch) >= N_CH);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    servo_chan #(
      .W        (W),
      .PW       (PW),
      .MIN_CYC  (MIN_CYC),
      .MAX_CYC  (MAX_CYC),
      .HOME_CYC (HOME_CYC),
      .STEP_CYC (STEP_CYC)
    ) u_chan (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .en          (en),
      .tick        (tick),
      .period_last (period_last),
      .period_cnt  (period_cnt),
      .inc         (inc[i]),
      .dec         (dec[i]),
      .cmd_load    (cmd_accept && (cmd_ch == 3'(i))),
      .cmd_pos     (cmd_pos),
      .pwm         (pwm[i]),
      .pos         (pos[i*W +: W]),
      .busy        (busy_vec[i])
    );
  end

  assign busy = |busy_vec;

endmodule
